// File: rtl/dsp_mode_scheduler.sv
// dsp_mode_scheduler: round-robin sharing of one fracturable signed DSP between two requesters; SCHED_STATS_EN adds stats ports
module dsp_mode_scheduler #(
  parameter int N   = 9,
  parameter int M   = 9,
  parameter int LAT = 3,
  parameter int II  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [3:0]       i_req_mode,
  input  logic [2*N-1:0]   i_req_aa,
  input  logic [2*M-1:0]   i_req_bb,
  output logic             o_dsp_start,
  output logic [1:0]       o_dsp_mode,
  output logic [N-1:0]     o_dsp_aa,
  output logic [M-1:0]     o_dsp_bb,
  input  logic [N+M-1:0]   i_dsp_out,
  output logic [1:0]       o_res_valid,
  output logic [N+M-1:0]   o_res_data,
  output logic             o_busy
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]      o_stat_issued,
  output logic [31:0]      o_stat_switch_cyc
`endif
);
  localparam int CW = $clog2(II + 1);
  typedef enum logic [1:0] {RUN, DRAIN, SETTLE} state_t;
  state_t           r_state, w_next;
  logic             r_ptr;
  logic [1:0]       r_cur_mode, r_tgt;
  logic [CW-1:0]    r_cnt;
  logic [LAT:0]     r_pv, r_pid;
  logic [LAT:0][1:0] r_pm;
  logic             w_win, w_any, w_run, w_acc, w_mis, w_drained;
  logic [1:0]       w_raw, w_wmode;
  logic [N+M-1:0]   w_ext;
  assign o_dsp_mode = r_cur_mode;
  assign o_busy     = (r_state != RUN) || |r_pv;
  always_comb begin
    w_win     = i_req_valid[r_ptr] ? r_ptr : ~r_ptr;
    w_raw     = w_win ? i_req_mode[3:2] : i_req_mode[1:0];
    w_wmode   = (w_raw == 2'b11) ? 2'b10 : w_raw;
    w_any     = |i_req_valid;
    w_run     = (r_state == RUN);
    w_acc     = w_run && w_any && (w_wmode == r_cur_mode);
    w_mis     = w_run && w_any && (w_wmode != r_cur_mode);
    // the oldest stage may retire in the same cycle DRAIN exits
    w_drained = ~|r_pv[LAT-1:0];
    o_req_ready = w_acc ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    w_next = w_mis ? DRAIN :
             (r_state == DRAIN && w_drained) ? SETTLE :
             (r_state == SETTLE && r_cnt == '0) ? RUN : r_state;
    w_ext = (r_pm[LAT] == 2'b00) ? {{(N+M-10){i_dsp_out[9]}}, i_dsp_out[9:0]} :
            (r_pm[LAT] == 2'b01) ? {{(N+M-15){i_dsp_out[14]}}, i_dsp_out[14:0]} : i_dsp_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_ptr       <= 1'b0;
      r_cur_mode  <= 2'b10;
      r_tgt       <= 2'b10;
      r_cnt       <= '0;
      r_pv        <= '0;
      r_pid       <= '0;
      r_pm        <= '0;
      o_dsp_start <= 1'b0;
      o_dsp_aa    <= '0;
      o_dsp_bb    <= '0;
      o_res_valid <= 2'b00;
      o_res_data  <= '0;
    end else begin
      r_state     <= w_next;
      o_dsp_start <= w_acc;
      if (w_acc) begin
        r_ptr    <= ~w_win;
        o_dsp_aa <= w_win ? i_req_aa[2*N-1:N] : i_req_aa[N-1:0];
        o_dsp_bb <= w_win ? i_req_bb[2*M-1:M] : i_req_bb[M-1:0];
      end
      if (w_mis) r_tgt <= w_wmode;
      if (r_state == DRAIN && w_drained) begin
        r_cur_mode <= r_tgt;
        r_cnt      <= CW'(II);
      end else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      r_pv  <= {r_pv[LAT-1:0], w_acc};
      r_pid <= {r_pid[LAT-1:0], w_win};
      r_pm  <= {r_pm[LAT-1:0], w_wmode};
      o_res_valid <= {r_pv[LAT] & r_pid[LAT], r_pv[LAT] & ~r_pid[LAT]};
      if (r_pv[LAT]) o_res_data <= w_ext;
    end
  end
`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_issued     <= '0;
      o_stat_switch_cyc <= '0;
    end else begin
      if (o_dsp_start && ~&o_stat_issued) o_stat_issued <= o_stat_issued + 1'b1;
      if (!w_run && ~&o_stat_switch_cyc) o_stat_switch_cyc <= o_stat_switch_cyc + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dsp_mode_scheduler.sv
// tb_dsp_mode_scheduler: directed scoreboard bench with a behavioural LAT=3 DSP model
module tb_dsp_mode_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_mode = 4'b1010;
  logic [17:0] req_aa = '0;
  logic [17:0] req_bb = '0;
  logic        dsp_start;
  logic [1:0]  dsp_mode;
  logic [8:0]  dsp_aa, dsp_bb;
  logic [17:0] dsp_out, d1, d2, d3;
  logic [1:0]  res_valid;
  logic [17:0] res_data;
  logic        busy;
`ifdef SCHED_STATS_EN
  logic [31:0] stat_issued, stat_switch_cyc;
`endif
  typedef struct {logic [1:0] v; logic [17:0] d; int cyc;} exp_t;
  exp_t q[$];
  exp_t me;
  int errs = 0, checks = 0, cyc = 0;
  int k, t, s;

  dsp_mode_scheduler #(.N(9), .M(9), .LAT(3), .II(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_mode(req_mode),
    .i_req_aa(req_aa), .i_req_bb(req_bb),
    .o_dsp_start(dsp_start), .o_dsp_mode(dsp_mode), .o_dsp_aa(dsp_aa), .o_dsp_bb(dsp_bb),
    .i_dsp_out(dsp_out), .o_res_valid(res_valid), .o_res_data(res_data), .o_busy(busy)
`ifdef SCHED_STATS_EN
    , .o_stat_issued(stat_issued), .o_stat_switch_cyc(stat_switch_cyc)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // product placed in the low bits only, so the scheduler must do the sign extension
  function automatic logic [17:0] dsp_f(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b);
    logic signed [17:0] sa, sb, p;
    sa = m[1] ? 18'($signed(a)) : 18'($signed(a[4:0]));
    sb = (m == 2'b00) ? 18'($signed(b[4:0])) : 18'($signed(b));
    p = sa * sb;
    return m[1] ? p : (m[0] ? {3'b0, p[14:0]} : {8'b0, p[9:0]});
  endfunction

  always @(posedge clk) begin
    d1 <= dsp_f(dsp_mode, dsp_aa, dsp_bb);
    d2 <= d1;
    d3 <= d2;
  end
  assign dsp_out = d3;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [17:0] d, input int c);
    exp_t e;
    e.v = v;
    e.d = d;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic setreq(input int r, input logic [1:0] m, input logic [8:0] a, input logic [8:0] b);
    req_mode[2*r +: 2] = m;
    req_aa[9*r +: 9] = a;
    req_bb[9*r +: 9] = b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  always @(negedge clk) begin
    if (res_valid != 2'b00) begin
      if (q.size() == 0) chk("res_unexpected", 32'(res_valid), 32'd0);
      else begin
        me = q.pop_front();
        chk("res_valid", 32'(res_valid), 32'(me.v));
        chk("res_data", 32'(res_data), 32'(me.d));
        if (me.cyc >= 0) chk("res_cycle", cyc, me.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_dsp_mode", 32'(dsp_mode), 32'h2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(dsp_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    tick();
    rst = 1'b0;
    // single requester, full mode
    setreq(0, 2'b10, 9'd3, 9'h1FE);
    req_valid = 2'b01;
    k = cyc;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    push(2'b01, 18'h3FFFA, k + 5);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_start", 32'(dsp_start), 32'd1);
    chk("t1_aa", 32'(dsp_aa), 32'd3);
    chk("t1_bb", 32'(dsp_bb), 32'h1FE);
    chk("t1_mode", 32'(dsp_mode), 32'h2);
    drain();
    // both requesting every cycle; pointer sits on B after the previous grant
    setreq(0, 2'b10, 9'd2, 9'd7);
    setreq(1, 2'b10, 9'h1FC, 9'd5);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i > 0) chk("t2_start", 32'(dsp_start), 32'd1);
      if (i % 2 == 0) push(2'b10, 18'h3FFEC, -1);
      else push(2'b01, 18'h0000E, -1);
      tick();
    end
    req_valid = 2'b00;
    @(negedge clk);
    chk("t2_start_last", 32'(dsp_start), 32'd1);
    drain();
    // mode switch 10 -> 00
    setreq(0, 2'b10, 9'd1, 9'd1);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t3_ready_a", 32'(req_ready), 32'h1);
    push(2'b01, 18'h00001, cyc + 5);
    tick();
    t = cyc;
    setreq(1, 2'b00, 9'h01D, 9'd5);
    req_valid = 2'b10;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      if (j == 0) chk("t3_start_a", 32'(dsp_start), 32'd1);
      if (j == 4) chk("t3_busy", 32'(busy), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("t3_ready_b_cycle", cyc, t + 9);
    chk("t3_ready_b", 32'(req_ready), 32'h2);
    push(2'b10, 18'h3FFF1, cyc + 5);
    tick();
    s = cyc;
    setreq(0, 2'b01, 9'h01F, 9'd100);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t3_start_b", 32'(dsp_start), 32'd1);
    chk("t3_mode_b", 32'(dsp_mode), 32'h0);
    chk("t3_aa_b", 32'(dsp_aa), 32'h01D);
    // mode switch 00 -> 01, accept exactly LAT+2+II after the last start
    for (int j = 0; j < 30 && req_ready != 2'b01; j++) begin
      tick();
      @(negedge clk);
    end
    chk("t4_accept_cycle", cyc, s + 9);
    chk("t4_ready", 32'(req_ready), 32'h1);
    push(2'b01, 18'h3FF9C, cyc + 5);
`ifdef SCHED_STATS_EN
    chk("stat_issued", stat_issued, 32'd7);
    chk("stat_switch_cyc", stat_switch_cyc, 32'd16);
`endif
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t4_mode", 32'(dsp_mode), 32'h1);
    drain();
    // reset with two ops in flight
    setreq(0, 2'b01, 9'd1, 9'd1);
    setreq(1, 2'b01, 9'd1, 9'd1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_ready_b", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("t5_ready_a", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    setreq(0, 2'b10, 9'd7, 9'h1FF);
    setreq(1, 2'b10, 9'd1, 9'd1);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_mode", 32'(dsp_mode), 32'h2);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'h1);
    push(2'b01, 18'h3FFF9, cyc + 5);
`ifdef SCHED_STATS_EN
    chk("stat_issued_rst", stat_issued, 32'd0);
    chk("stat_switch_rst", stat_switch_cyc, 32'd0);
`endif
    tick();
    req_valid = 2'b00;
    drain();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
